// File: rtl/chroma_pkg.sv
// -----------------------------------------------------------------------------
// chroma_pkg
// Shared types and constants for the chroma control / pixel painter pair.
//   rgb3_t      : 3-bit {R,G,B} colour
//   ton_t       : 8-bit dim threshold
//   s1_t        : payload carried by the first pixel pipeline stage
//   pixel_color : maps a stage-1 payload to the colour driven to the VGA stage
// The constants double as the chroma control block's reset values.
// -----------------------------------------------------------------------------
package chroma_pkg;

    typedef logic [2:0] rgb3_t;
    typedef logic [7:0] ton_t;

    localparam ton_t  TON_DEFAULT = 8'hA4;
    localparam rgb3_t COLOR_BLACK = 3'b000;
    localparam rgb3_t COLOR_WHITE = 3'b111;

    // Everything stage 2 needs to pick a colour, frozen at accept time so a
    // later settings swap cannot reach a pixel that is already in flight.
    typedef struct packed {
        logic  glyph;   // 1 = letter, 0 = background
        logic  active;  // pixel lies in the visible area
        logic  blank;   // dimmed to black (only ever set with dimming built)
        rgb3_t col_l;   // letter colour in effect for this pixel
        rgb3_t col_p;   // background colour in effect for this pixel
    } s1_t;

    function automatic rgb3_t pixel_color(input s1_t s);
        rgb3_t c;
        c = COLOR_BLACK;
        if (s.active && !s.blank) begin
            c = s.glyph ? s.col_l : s.col_p;
        end
        return c;
    endfunction

endpackage

// File: rtl/chroma_pipe_stage.sv
// -----------------------------------------------------------------------------
// chroma_pipe_stage
// Generic one-entry valid/ready register slice. Ready toward the producer is
// combinational from downstream ready, so a full slice still moves one item
// per clock when the consumer keeps accepting (no bubble).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_up_valid      : producer has data
//   o_up_ready      : slice will load this cycle (empty or draining)
//   i_up_data [W]   : producer data
//   o_dn_valid      : slice holds data
//   i_dn_ready      : consumer takes data this cycle
//   o_dn_data [W]   : held data, stable while o_dn_valid && !i_dn_ready
// -----------------------------------------------------------------------------
module chroma_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_up_valid,
    output logic         o_up_ready,
    input  logic [W-1:0] i_up_data,
    output logic         o_dn_valid,
    input  logic         i_dn_ready,
    output logic [W-1:0] o_dn_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign w_load     = !r_valid || i_dn_ready;
    assign o_up_ready = w_load;
    assign o_dn_valid = r_valid;
    assign o_dn_data  = r_data;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of
    // statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            // NOTE: the data register is reset as well so the output reads
            // black straight out of reset instead of an unknown value.
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_up_valid;
            // Data only moves with a real item; an emptied slice keeps
            // showing the last pixel rather than a don't-care.
            if (i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

endmodule

// File: rtl/chroma_pixel_painter.sv
// -----------------------------------------------------------------------------
// chroma_pixel_painter
// Turns the renderer's glyph-bit stream into 3-bit RGB pixels for the VGA
// stage. Chroma settings (threshold, letter and background colour) are
// shadowed and swapped only on an accepted frame-start pixel, so a button
// press never tears a frame. Two register slices give a 2-cycle latency,
// 1 pixel/clk throughput and full backpressure. A saturating counter reports
// the pixels accepted in the current frame.
//
// Optional feature (macro CHROMA_PAINTER_DIM_EN):
//   defined   - an 8-bit dim counter numbers the pixels of a frame from 0 and
//               active pixels whose number is >= the threshold go black.
//   undefined - the threshold is shadowed but does not affect rgb_o.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   ton_i          : threshold from chroma control
//   color_l_i      : letter colour from chroma control
//   color_p_i      : background colour from chroma control
//   frame_start_i  : marks the first pixel of a frame (qualified by accept)
//   pix_valid_i    : input pixel valid
//   pix_ready_o    : input pixel ready (combinational from rgb_ready_i)
//   pix_bit_i      : glyph bit, 1 = letter
//   pix_active_i   : pixel in visible area
//   rgb_valid_o    : output pixel valid
//   rgb_ready_i    : output pixel ready
//   rgb_o          : output colour {R,G,B}
//   frame_cnt_o    : pixels accepted this frame, saturating
// -----------------------------------------------------------------------------
module chroma_pixel_painter
    import chroma_pkg::*;
#(
    parameter int    CNT_W       = 16,
    parameter ton_t  TON_RST     = TON_DEFAULT,
    parameter rgb3_t COLOR_L_RST = COLOR_BLACK,
    parameter rgb3_t COLOR_P_RST = COLOR_WHITE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ton_i,
    input  logic [2:0]       color_l_i,
    input  logic [2:0]       color_p_i,
    input  logic             frame_start_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    input  logic             pix_bit_i,
    input  logic             pix_active_i,
    output logic             rgb_valid_o,
    input  logic             rgb_ready_i,
    output logic [2:0]       rgb_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    // Shadow settings for the frame in progress.
    ton_t  r_ton;
    rgb3_t r_color_l;
    rgb3_t r_color_p;

    logic [CNT_W-1:0] r_frame_cnt;

    logic  w_s1_ready;
    logic  w_s1_valid;
    logic  w_s2_ready;
    logic  w_accept;
    logic  w_fs_accept;
    logic  w_blank;
    ton_t  w_ton_eff;
    rgb3_t w_color_l_eff;
    rgb3_t w_color_p_eff;
    s1_t   w_s1_d;
    s1_t   w_s1_q;
    rgb3_t w_rgb_next;

    assign pix_ready_o = w_s1_ready;
    assign w_accept    = pix_valid_i && w_s1_ready;
    assign w_fs_accept = w_accept && frame_start_i;

    // The frame-start pixel already uses the incoming settings, so bypass the
    // shadows on that cycle rather than wait for them to load.
    assign w_ton_eff     = w_fs_accept ? ton_i     : r_ton;
    assign w_color_l_eff = w_fs_accept ? color_l_i : r_color_l;
    assign w_color_p_eff = w_fs_accept ? color_p_i : r_color_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ton     <= TON_RST;
            r_color_l <= COLOR_L_RST;
            r_color_p <= COLOR_P_RST;
        end else if (w_fs_accept) begin
            r_ton     <= ton_i;
            r_color_l <= color_l_i;
            r_color_p <= color_p_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            if (frame_start_i) begin
                r_frame_cnt <= CNT_W'(1);
            end else if (r_frame_cnt != {CNT_W{1'b1}}) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign frame_cnt_o = r_frame_cnt;

`ifdef CHROMA_PAINTER_DIM_EN
    ton_t r_dim_cnt;
    ton_t w_dim_eff;

    // r_dim_cnt holds the number the next accepted pixel will get; a
    // frame-start pixel is always number 0. The count wraps after 255.
    assign w_dim_eff = frame_start_i ? 8'd0 : r_dim_cnt;
    assign w_blank   = (w_dim_eff >= w_ton_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dim_cnt <= 8'd0;
        end else if (w_accept) begin
            r_dim_cnt <= w_dim_eff + 8'd1;
        end
    end
`else
    // The threshold is still shadowed for the control path but has no
    // effect on the colour in this build.
    logic w_unused_ton;
    assign w_unused_ton = ^w_ton_eff;
    assign w_blank      = 1'b0;
`endif

    always_comb begin
        w_s1_d        = '0;
        w_s1_d.glyph  = pix_bit_i;
        w_s1_d.active = pix_active_i;
        w_s1_d.blank  = w_blank;
        w_s1_d.col_l  = w_color_l_eff;
        w_s1_d.col_p  = w_color_p_eff;
    end

    assign w_rgb_next = pixel_color(w_s1_q);

    // Stage 1: glyph bit, visibility and the colours in effect at accept.
    chroma_pipe_stage #(
        .W ($bits(s1_t))
    ) u_stage1 (
        .clk        (clk),
        .reset      (reset),
        .i_up_valid (pix_valid_i),
        .o_up_ready (w_s1_ready),
        .i_up_data  (w_s1_d),
        .o_dn_valid (w_s1_valid),
        .i_dn_ready (w_s2_ready),
        .o_dn_data  (w_s1_q)
    );

    // Stage 2: final colour, held stable while the VGA stage stalls.
    chroma_pipe_stage #(
        .W ($bits(rgb3_t))
    ) u_stage2 (
        .clk        (clk),
        .reset      (reset),
        .i_up_valid (w_s1_valid),
        .o_up_ready (w_s2_ready),
        .i_up_data  (w_rgb_next),
        .o_dn_valid (rgb_valid_o),
        .i_dn_ready (rgb_ready_i),
        .o_dn_data  (rgb_o)
    );

endmodule
